// File: rtl/nand_response_checker_pkg.sv
// nand_chk_pkg: shared state encoding, defaults and reference NAND for the response checker
package nand_chk_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_WAIT_VEC, ST_SETTLE, ST_CHECK, ST_DONE} state_t;
    localparam int DEF_N_IN = 3;
    localparam int DEF_SETTLE = 1;
    localparam int DEF_CNT_W = 8;
    function automatic logic nand_exp(input logic [31:0] v, input int n);
        logic a;
        a = 1'b1;
        for (int i = 0; i < n; i++) a &= v[i];
        return ~a;
    endfunction
endpackage

// File: rtl/nand_response_checker_if.sv
// nand_response_checker_if: stimulus vector valid/ready stream between source and checker
interface nand_response_checker_if #(parameter int N_IN = 3);
    logic            vec_valid;
    logic            vec_ready;
    logic [N_IN-1:0] vec;
    logic            vec_last;
    modport master (output vec_valid, vec, vec_last, input vec_ready);
    modport slave (input vec_valid, vec, vec_last, output vec_ready);
endinterface

// File: rtl/nand_response_checker_sat_counter.sv
// sat_counter: clearable up-counter that sticks at its all-ones value
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] value
);
    logic [W-1:0] value_q, value_d;
    always_comb value_d = clear ? '0 : (inc && value_q != '1) ? value_q + 1'b1 : value_q;
    always_ff @(posedge clk) value_q <= rst ? '0 : value_d;
    assign value = value_q;
endmodule

// File: rtl/nand_response_checker.sv
// nand_response_checker: accepts NAND stimulus vectors, settles, checks two gate outputs and tallies errors
module nand_response_checker
    import nand_chk_pkg::*;
#(
    parameter int N_IN   = DEF_N_IN,
    parameter int SETTLE = DEF_SETTLE,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    nand_response_checker_if.slave  vif,
    input  logic                    out_a,
    input  logic                    out_b,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [CNT_W-1:0]        err_count,
    output logic [N_IN-1:0]         first_fail_vec,
    output logic                    first_fail_valid
);
    localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;
    state_t state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d, ffv_q, ffv_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic last_q, last_d, ffval_q, ffval_d;
    logic ready_q, ready_d, busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic exp_v, mismatch, inc;
    always_comb begin
        state_d = state_q;
        vec_d = vec_q;
        last_d = last_q;
        cnt_d = cnt_q;
        ffv_d = ffv_q;
        ffval_d = ffval_q;
        inc = 1'b0;
        exp_v = nand_exp(32'(vec_q), N_IN);
        mismatch = (out_a != exp_v) | (out_b != exp_v);
        // start wins in every state: it aborts any in-flight vector and clears results
        if (start) begin
            state_d = ST_WAIT_VEC;
            ffv_d = '0;
            ffval_d = 1'b0;
        end else begin
            case (state_q)
                ST_WAIT_VEC: if (vif.vec_valid && ready_q) begin
                    vec_d = vif.vec;
                    last_d = vif.vec_last;
                    cnt_d = SW'(SETTLE - 1);
                    state_d = SETTLE > 0 ? ST_SETTLE : ST_CHECK;
                end
                ST_SETTLE: begin
                    cnt_d = cnt_q - 1'b1;
                    state_d = cnt_q == '0 ? ST_CHECK : ST_SETTLE;
                end
                ST_CHECK: begin
                    inc = mismatch;
                    ffv_d = (mismatch && !ffval_q) ? vec_q : ffv_q;
                    ffval_d = ffval_q | mismatch;
                    state_d = last_q ? ST_DONE : ST_WAIT_VEC;
                end
                default: ;
            endcase
        end
        ready_d = state_d == ST_WAIT_VEC;
        busy_d = state_d inside {ST_WAIT_VEC, ST_SETTLE, ST_CHECK};
        done_d = state_d == ST_DONE;
        pass_d = done_d && !inc && err_count == '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q <= '0;
            last_q <= 1'b0;
            cnt_q <= '0;
            ffv_q <= '0;
            ffval_q <= 1'b0;
            ready_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q <= vec_d;
            last_q <= last_d;
            cnt_q <= cnt_d;
            ffv_q <= ffv_d;
            ffval_q <= ffval_d;
            ready_q <= ready_d;
            busy_q <= busy_d;
            done_q <= done_d;
            pass_q <= pass_d;
        end
    end
    sat_counter #(.W(CNT_W)) u_err (
        .clk(clk),
        .rst(rst),
        .clear(start),
        .inc(inc),
        .value(err_count)
    );
    assign vif.vec_ready = ready_q;
    assign busy = busy_q;
    assign done = done_q;
    assign pass = pass_q;
    assign first_fail_vec = ffv_q;
    assign first_fail_valid = ffval_q;
endmodule

// File: tb/tb_nand_response_checker.sv
// tb_nand_response_checker: scoreboard bench driving two checker configurations with a NAND gate model
module tb_nand_response_checker;
    typedef struct {
        int         err;
        logic       ffval;
        logic [2:0] ffv;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic start [2], vvalid [2], vlast [2], rdy [2];
    logic out_a [2], out_b [2], busy [2], done [2], pass [2], ffval [2];
    logic [2:0] vvec [2], ffv [2], applied [2];
    logic [7:0] err0;
    logic [1:0] err1;
    logic [7:0] flip_a, flip_b;
    logic stuck_b;

    nand_response_checker_if #(.N_IN(3)) if0 ();
    nand_response_checker_if #(.N_IN(3)) if1 ();
    assign if0.vec_valid = vvalid[0];
    assign if0.vec = vvec[0];
    assign if0.vec_last = vlast[0];
    assign rdy[0] = if0.vec_ready;
    assign if1.vec_valid = vvalid[1];
    assign if1.vec = vvec[1];
    assign if1.vec_last = vlast[1];
    assign rdy[1] = if1.vec_ready;

    // gate model: the device under test sees the most recently accepted vector
    always @(posedge clk)
        for (int i = 0; i < 2; i++) if (vvalid[i] && rdy[i]) applied[i] <= vvec[i];
    always_comb
        for (int i = 0; i < 2; i++) begin
            out_a[i] = (~&applied[i]) ^ flip_a[applied[i]];
            out_b[i] = stuck_b ? 1'b1 : ((~&applied[i]) ^ flip_b[applied[i]]);
        end

    nand_response_checker #(.N_IN(3), .SETTLE(1), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .vif(if0),
        .out_a(out_a[0]), .out_b(out_b[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_count(err0), .first_fail_vec(ffv[0]), .first_fail_valid(ffval[0])
    );
    nand_response_checker #(.N_IN(3), .SETTLE(0), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .vif(if1),
        .out_a(out_a[1]), .out_b(out_b[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_count(err1), .first_fail_vec(ffv[1]), .first_fail_valid(ffval[1])
    );

    exp_t sb[$];
    int n_cmp = 0, n_bad = 0;
    int m_err;
    logic m_ffval;
    logic [2:0] m_ffv;
    int acc [8];
    int start_cyc, done_cyc;

    function automatic int err_of(input int s);
        return s != 0 ? int'(err1) : int'(err0);
    endfunction

    task automatic pulse_start(input int s);
        start[s] = 1'b1;
        @(posedge clk); #1;
        start[s] = 1'b0;
        start_cyc = cyc;
        m_err = 0;
        m_ffval = 1'b0;
        m_ffv = '0;
        sb.delete();
    endtask

    task automatic send(input int s, input logic [2:0] v, input logic last);
        logic r, bw;
        int n;
        n = 0;
        vvalid[s] = 1'b1;
        vvec[s] = v;
        vlast[s] = last;
        do begin
            r = rdy[s];
            @(posedge clk); #1;
            n++;
        end while (!r && n < 64);
        n_cmp++;
        if (!r) begin
            n_bad++;
            $display("FAIL accept_timeout vec=%0d ready=%b required=1", v, r);
        end
        acc[v] = cyc;
        bw = stuck_b ? ((~&v) != 1'b1) : flip_b[v];
        if (flip_a[v] || bw) begin
            if (m_err < (s != 0 ? 3 : 255)) m_err++;
            if (!m_ffval) m_ffv = v;
            m_ffval = 1'b1;
        end
        sb.push_back('{m_err, m_ffval, m_ffv});
        if (last) vvalid[s] = 1'b0;
    endtask

    task automatic finish_vec(input int s);
        exp_t e;
        int n;
        n = 0;
        while (!(rdy[s] || done[s]) && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        e = sb.pop_front();
        n_cmp++;
        if (n >= 64 || err_of(s) !== e.err || ffval[s] !== e.ffval) begin
            n_bad++;
            $display("FAIL vec_result dut=%0d err=%0d ffval=%b waited=%0d required err=%0d ffval=%b",
                     s, err_of(s), ffval[s], n, e.err, e.ffval);
        end
    endtask

    task automatic sweep(input int s);
        pulse_start(s);
        for (int k = 0; k < 8; k++) begin
            send(s, 3'(k), k == 7);
            finish_vec(s);
        end
        done_cyc = cyc;
        n_cmp++;
        if (done[s] !== 1'b1 || busy[s] !== 1'b0 || pass[s] !== (m_err == 0) || ffv[s] !== m_ffv) begin
            n_bad++;
            $display("FAIL sweep_end dut=%0d done=%b busy=%b pass=%b ffv=%0d required 1 0 %b %0d",
                     s, done[s], busy[s], pass[s], ffv[s], m_err == 0, m_ffv);
        end
        for (int k = 1; k < 8; k++) begin
            n_cmp++;
            if (acc[k] - acc[k-1] != (s != 0 ? 2 : 3)) begin
                n_bad++;
                $display("FAIL accept_spacing dut=%0d vec=%0d gap=%0d required=%0d",
                         s, k, acc[k] - acc[k-1], s != 0 ? 2 : 3);
            end
        end
    endtask

    task automatic test_reset;
        for (int s = 0; s < 2; s++) begin
            n_cmp++;
            if ({rdy[s], busy[s], done[s], pass[s], ffval[s], ffv[s]} !== 8'b0 || err_of(s) !== 0) begin
                n_bad++;
                $display("FAIL reset dut=%0d rdy=%b busy=%b done=%b pass=%b ffval=%b ffv=%0d err=%0d required all 0",
                         s, rdy[s], busy[s], done[s], pass[s], ffval[s], ffv[s], err_of(s));
            end
        end
    endtask

    task automatic test_clean_sweep;
        flip_a = '0;
        flip_b = '0;
        stuck_b = 1'b0;
        sweep(0);
        n_cmp++;
        if (done_cyc - start_cyc != 24 || err0 !== 8'd0 || ffval[0] !== 1'b0 || pass[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL clean_sweep cycles=%0d err=%0d ffval=%b pass=%b required 24 0 0 1",
                     done_cyc - start_cyc, err0, ffval[0], pass[0]);
        end
    endtask

    task automatic test_stuck_b;
        stuck_b = 1'b1;
        pulse_start(0);
        n_cmp++;
        if (done[0] !== 1'b0 || busy[0] !== 1'b1 || rdy[0] !== 1'b1 || pass[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL restart_from_done done=%b busy=%b rdy=%b pass=%b required 0 1 1 0",
                     done[0], busy[0], rdy[0], pass[0]);
        end
        sweep(0);
        n_cmp++;
        if (err0 !== 8'd1 || ffv[0] !== 3'b111 || ffval[0] !== 1'b1 || pass[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL stuck_b err=%0d ffv=%0d ffval=%b pass=%b required 1 7 1 0",
                     err0, ffv[0], ffval[0], pass[0]);
        end
        stuck_b = 1'b0;
    endtask

    task automatic test_flip_a;
        flip_a = 8'b0010_0100;
        flip_b = 8'b0010_0000;
        sweep(0);
        n_cmp++;
        if (err0 !== 8'd2 || ffv[0] !== 3'b010 || ffval[0] !== 1'b1 || pass[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL flip_a err=%0d ffv=%0d ffval=%b pass=%b required 2 2 1 0",
                     err0, ffv[0], ffval[0], pass[0]);
        end
        flip_b = '0;
    endtask

    task automatic test_back_to_back;
        flip_a = 8'hFF;
        sweep(1);
        n_cmp++;
        if (err1 !== 2'd3 || pass[1] !== 1'b0 || ffv[1] !== 3'd0 || ffval[1] !== 1'b1 || done_cyc - acc[7] != 1) begin
            n_bad++;
            $display("FAIL saturate err=%0d pass=%b ffv=%0d ffval=%b done_lag=%0d required 3 0 0 1 1",
                     err1, pass[1], ffv[1], ffval[1], done_cyc - acc[7]);
        end
    endtask

    task automatic test_abort;
        flip_a = 8'b0001_0100;
        pulse_start(0);
        for (int k = 0; k < 4; k++) begin
            send(0, 3'(k), 1'b0);
            finish_vec(0);
        end
        send(0, 3'd4, 1'b0);
        vvalid[0] = 1'b0;
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        sb.delete();
        n_cmp++;
        if (rdy[0] !== 1'b1 || err0 !== 8'd0 || ffval[0] !== 1'b0 || ffv[0] !== 3'd0 || busy[0] !== 1'b1 || done[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_clear rdy=%b err=%0d ffval=%b ffv=%0d busy=%b done=%b required 1 0 0 0 1 0",
                     rdy[0], err0, ffval[0], ffv[0], busy[0], done[0]);
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (err0 !== 8'd0 || rdy[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_discard err=%0d rdy=%b required 0 1", err0, rdy[0]);
        end
    endtask

    task automatic test_rst_check;
        flip_a = 8'hFF;
        pulse_start(0);
        send(0, 3'd5, 1'b0);
        finish_vec(0);
        send(0, 3'd6, 1'b1);
        @(posedge clk); #1;
        n_cmp++;
        if (busy[0] !== 1'b1 || rdy[0] !== 1'b0 || err0 !== 8'd1) begin
            n_bad++;
            $display("FAIL pre_rst busy=%b rdy=%b err=%0d required 1 0 1", busy[0], rdy[0], err0);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({rdy[0], busy[0], done[0], pass[0], ffval[0], ffv[0]} !== 8'b0 || err0 !== 8'd0) begin
            n_bad++;
            $display("FAIL rst_in_check rdy=%b busy=%b done=%b pass=%b ffval=%b ffv=%0d err=%0d required all 0",
                     rdy[0], busy[0], done[0], pass[0], ffval[0], ffv[0], err0);
        end
        rst = 1'b0;
        sb.delete();
        flip_a = '0;
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            start[s] = 1'b0;
            vvalid[s] = 1'b0;
            vlast[s] = 1'b0;
            vvec[s] = '0;
        end
        flip_a = '0;
        flip_b = '0;
        stuck_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_clean_sweep();
        test_stuck_b();
        test_flip_a();
        test_back_to_back();
        test_abort();
        test_rst_check();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/nand_response_checker.md
# nand_response_checker

Response-side checker for the NAND gate comparison flow: accepts 3-input stimulus vectors from a source via a valid/ready handshake, waits a fixed settle time, samples two gate implementation outputs and checks both against the expected NAND. It accumulates a saturating error count, captures the first failing vector, and reports pass/fail when the final vector of a sweep has been checked. It sits opposite the stimulus generator, with the device under test between them, and makes the gate sweep self-checking in simulation and on hardware.

## Interface
- N_IN, 3: vector width; expected = ~&vec.
- SETTLE, 1: idle cycles between vector accept and output sample; 0 allowed.
- CNT_W, 8: error counter width.

- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; clears results and opens a session.
- vec_valid  in  1  stimulus vector present.
- vec_ready  out  1  checker can accept a vector.
- vec  in  N_IN  stimulus applied to the device under test.
- vec_last  in  1  qualifies vec as the final vector of the sweep.
- out_a  in  1  output of implementation A (3-input gate).
- out_b  in  1  output of implementation B (instantiated gates).
- busy  out  1  session open (not IDLE or DONE).
- done  out  1  sweep complete; held until start or rst.
- pass  out  1  valid when done; 1 iff err_count == 0.
- err_count  out  CNT_W  mismatching vectors, saturating.
- first_fail_vec  out  N_IN  first vector with a mismatch.
- first_fail_valid  out  1  first_fail_vec holds a captured vector.

## Operation
- FSM states: IDLE, WAIT_VEC, SETTLE, CHECK, DONE.
- IDLE: start -> WAIT_VEC. Clears err_count, first_fail_*, pass and done.
- WAIT_VEC: vec_ready=1. On vec_valid&vec_ready, latches vec and vec_last. Goes to SETTLE if SETTLE>0, else to CHECK.
- SETTLE: down-counter loaded with SETTLE-1; -> CHECK when it reaches 0.
- CHECK: exp = ~&vec_q. A mismatch is (out_a!=exp)|(out_b!=exp); one vector counts at most one error.
  - On mismatch, err_count increments and saturates at 2^CNT_W-1.
  - On the first mismatch only, first_fail_vec is loaded with vec_q and first_fail_valid is set.
  - Next state is DONE if last_q, else WAIT_VEC.
- DONE: done=1, pass=(err_count==0). start -> WAIT_VEC with results cleared.
- start in WAIT_VEC, SETTLE or CHECK aborts the session and restarts it: results cleared, -> WAIT_VEC. The in-flight vector is discarded and not counted.
- vec_valid outside WAIT_VEC is ignored; the source must hold it until accepted.

## Timing
- Reset values: vec_ready=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, first_fail_valid=0; state IDLE.
- rst mid-session forces the reset values on the next edge; no partial results are kept.
- Accept at edge T. Outputs are sampled in the CHECK cycle, which follows edge T+SETTLE. Counters update at edge T+SETTLE+1.
- Throughput: one vector per SETTLE+2 cycles. vec_ready re-asserts the cycle after CHECK.
- done rises at the edge after the CHECK of the last vector. pass becomes valid in the same cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package nand_chk_pkg holds:
  - the state enum;
  - function nand_exp(vec) returning ~&vec;
  - the SETTLE/CNT_W defaults.
- One sub-module: sat_counter (CNT_W, clear, inc, saturating value). It is used for err_count.
- The settle counter is inline.

## Test plan
- Sweep of vectors 0..7, vec_last on 7, out_a=out_b=~&vec, SETTLE=1 -> done after 24 cycles of handshakes, pass=1, err_count=0, first_fail_valid=0.
- Same sweep with out_b stuck at 1 -> err_count=1, first_fail_vec=3'b111, first_fail_valid=1, pass=0.
- out_a inverted on vectors 2 and 5 -> err_count=2, first_fail_vec=3'b010. Both outputs wrong on one vector -> that vector counts once.
- CNT_W=2 with every vector failing over 8 vectors -> err_count saturates at 3, pass=0.
- start pulsed during SETTLE of vector 4 -> vector 4 is not counted, results are cleared, vec_ready=1 the next cycle. rst during CHECK -> all outputs take their reset values at the next edge.
- SETTLE=0, vec_valid held high continuously -> one accept every 2 cycles; done 1 cycle after the last CHECK.
